// File: rtl/instr_compressor_pkg.sv
// Shared constants, FSM states and token builder
// for the pair-dictionary instruction compressor.
package compress_pkg;

  localparam int WIDTH = 32;
  localparam int encodeLength = 4;
  localparam logic [encodeLength-1:0] OPcode = 4'b1111;
  localparam int ENTRIES = 16;
  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    FLUSH
  } state_t;

  // Pair i lives at table bytes 8i / 8i+4.
  function automatic logic [WIDTH-1:0] make_token(
    input logic [IDX_W-1:0] idx
  );
    return {OPcode, (WIDTH-encodeLength)'(idx) << 3};
  endfunction

endpackage

// File: rtl/instr_compressor_if.sv
// Input and output valid/ready streams
// of the instruction compressor.
interface instr_compressor_if #(
  parameter int W = 32
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_instr;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_word;
  logic         out_token;
  logic         out_last;

  modport master (
    output in_valid, in_instr, in_last,
    output out_ready,
    input  in_ready,
    input  out_valid, out_word,
    input  out_token, out_last
  );

  modport slave (
    input  in_valid, in_instr, in_last,
    input  out_ready,
    output in_ready,
    output out_valid, out_word,
    output out_token, out_last
  );

endinterface

// File: rtl/instr_compressor_dict.sv
// Pair dictionary: storage, write port and
// parallel compare with lowest-index priority.
module pair_dict
  import compress_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wme,
  input  logic [IDX_W-1:0] wIdx,
  input  logic [WIDTH-1:0] wFirst,
  input  logic [WIDTH-1:0] wSecond,
  input  logic [WIDTH-1:0] key_first,
  input  logic [WIDTH-1:0] key_second,
  output logic             hit,
  output logic [IDX_W-1:0] hitIdx
);

  logic [ENTRIES-1:0] valid;
  logic [WIDTH-1:0]   first  [ENTRIES];
  logic [WIDTH-1:0]   second [ENTRIES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (wme) begin
      valid[wIdx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wme) begin
      first[wIdx]  <= wFirst;
      second[wIdx] <= wSecond;
    end
  end

  // Scan high to low so the lowest match is left standing.
  always_comb begin
    hit    = 1'b0;
    hitIdx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && first[i] == key_first &&
          second[i] == key_second) begin
        hit    = 1'b1;
        hitIdx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/instr_compressor.sv
// Streaming compressor: replaces dictionary
// pairs with token words, passes others raw.
module instr_compressor
  import compress_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wme,
  input  logic [IDX_W-1:0] wIdx,
  input  logic [WIDTH-1:0] wFirst,
  input  logic [WIDTH-1:0] wSecond,
  instr_compressor_if.slave s,
  output logic             collide,
  output logic [15:0]      tok_count,
  output logic [15:0]      raw_count
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] h_q;
  logic             ov_q;
  logic [WIDTH-1:0] ow_q;
  logic             ot_q;
  logic             ol_q;

  logic             adv;
  logic             in_rdy;
  logic             acc;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;

  logic             emit;
  logic             emit_tok;
  logic             emit_last;
  logic [WIDTH-1:0] emit_word;
  logic             load_h;

  pair_dict u_dict (
    .clk        (clk),
    .reset      (reset),
    .wme        (wme),
    .wIdx       (wIdx),
    .wFirst     (wFirst),
    .wSecond    (wSecond),
    .key_first  (h_q),
    .key_second (s.in_instr),
    .hit        (hit),
    .hitIdx     (hit_idx)
  );

  assign adv    = !ov_q || s.out_ready;
  assign in_rdy = adv && (state != FLUSH);
  assign acc    = s.in_valid && in_rdy;

  assign s.in_ready  = in_rdy;
  assign s.out_valid = ov_q;
  assign s.out_word  = ow_q;
  assign s.out_token = ot_q;
  assign s.out_last  = ol_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (acc && !s.in_last) state_nxt = HOLD;
      end
      HOLD: begin
        if (acc) begin
          if (hit)            state_nxt = IDLE;
          else if (s.in_last) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (adv) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    emit      = 1'b0;
    emit_tok  = 1'b0;
    emit_last = 1'b0;
    emit_word = h_q;
    load_h    = 1'b0;
    unique case (state)
      IDLE: begin
        if (acc) begin
          if (s.in_last) begin
            emit      = 1'b1;
            emit_last = 1'b1;
            emit_word = s.in_instr;
          end else begin
            load_h = 1'b1;
          end
        end
      end
      HOLD: begin
        if (acc) begin
          emit = 1'b1;
          if (hit) begin
            emit_tok  = 1'b1;
            emit_last = s.in_last;
            emit_word = make_token(hit_idx);
          end else begin
            load_h = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (adv) begin
          emit      = 1'b1;
          emit_last = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q <= '0;
    end else if (load_h) begin
      h_q <= s.in_instr;
    end
  end

  // Output word only moves when the consumer can take it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ov_q <= 1'b0;
      ow_q <= '0;
      ot_q <= 1'b0;
      ol_q <= 1'b0;
    end else if (adv) begin
      ov_q <= emit;
      if (emit) begin
        ow_q <= emit_word;
        ot_q <= emit_tok;
        ol_q <= emit_last;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tok_count <= '0;
      raw_count <= '0;
      collide   <= 1'b0;
    end else if (emit) begin
      if (emit_tok) begin
        tok_count <= tok_count + 16'd1;
      end else begin
        raw_count <= raw_count + 16'd1;
        if (emit_word[WIDTH-1 -: encodeLength] == OPcode)
          collide <= 1'b1;
      end
    end
  end

endmodule
